// File: rtl/axis_frame_arb_mux.sv
// rtl/axis_frame_arb_mux.sv - frame-aware round-robin AXI-Stream arbiter/mux
// Holds one grant per frame; registered output stage backed by a one-entry skid buffer.
module axis_frame_arb_mux #(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int LAST_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int SEL_WIDTH   = (S_COUNT > 1 ? $clog2(S_COUNT) : 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic                          grant_valid,
  output logic [SEL_WIDTH-1:0]          grant_index
);

  localparam int BEAT_W = USER_WIDTH + 1 + KEEP_WIDTH + DATA_WIDTH;

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_next;

  logic [SEL_WIDTH-1:0]  last_grant;
  logic [SEL_WIDTH-1:0]  arb_index;
  logic                  arb_found;
  logic [SEL_WIDTH-1:0]  scan_sel;
  int                    scan_idx;

  logic [DATA_WIDTH-1:0] sel_tdata;
  logic [KEEP_WIDTH-1:0] sel_tkeep;
  logic                  sel_tvalid;
  logic                  sel_tlast;
  logic [USER_WIDTH-1:0] sel_tuser;
  logic                  accept;
  logic [BEAT_W-1:0]     beat_in;

  logic                  out_valid;
  logic [BEAT_W-1:0]     out_beat;
  logic                  skid_valid;
  logic [BEAT_W-1:0]     skid_beat;

  // Scan upward from the input after the last grant, wrapping once.
  always_comb begin
    arb_index = '0;
    arb_found = 1'b0;
    scan_idx  = 0;
    scan_sel  = '0;
    for (int k = 0; k < S_COUNT; k++) begin
      scan_idx = int'(last_grant) + 1 + k;
      if (scan_idx >= S_COUNT) scan_idx = scan_idx - S_COUNT;
      scan_sel = scan_idx[SEL_WIDTH-1:0];
      if (!arb_found && s_axis_tvalid[scan_sel]) begin
        arb_found = 1'b1;
        arb_index = scan_sel;
      end
    end
  end

  // Granted-input mux and per-input ready; only the granted input may see ready.
  always_comb begin
    sel_tdata     = '0;
    sel_tkeep     = '0;
    sel_tvalid    = 1'b0;
    sel_tlast     = 1'b0;
    sel_tuser     = '0;
    s_axis_tready = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_index == SEL_WIDTH'(i)) begin
        sel_tdata        = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tkeep        = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] | {KEEP_WIDTH{KEEP_ENABLE == 0}};
        sel_tvalid       = s_axis_tvalid[i];
        sel_tlast        = s_axis_tlast[i] | (LAST_ENABLE == 0);
        sel_tuser        = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        s_axis_tready[i] = (state == ACTIVE) && !skid_valid;
      end
    end
  end

  assign accept  = (state == ACTIVE) && !skid_valid && sel_tvalid;
  assign beat_in = {sel_tuser, sel_tlast, sel_tkeep, sel_tdata};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arb_found) state_next = ACTIVE;
      ACTIVE:  if (accept && sel_tlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pointer starts at the last input so input 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_index <= '0;
      last_grant  <= SEL_WIDTH'(S_COUNT - 1);
    end else if (state == IDLE && arb_found) begin
      grant_index <= arb_index;
    end else if (accept && sel_tlast) begin
      last_grant  <= grant_index;
    end
  end

  assign grant_valid = (state == ACTIVE);

  // Output register refills from the skid first; the skid only fills while the output stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_beat   <= '0;
      skid_valid <= 1'b0;
      skid_beat  <= '0;
    end else if (!out_valid || m_axis_tready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_beat   <= skid_beat;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) out_beat <= beat_in;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_beat  <= beat_in;
    end
  end

  assign m_axis_tvalid = out_valid;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_beat;

endmodule

// File: tb/tb_axis_frame_arb_mux.sv
// tb/tb_axis_frame_arb_mux.sv - directed bench for axis_frame_arb_mux
// Cycle table for basic grant/reset timing, queue-driven sequences for multi-cycle cases.
module tb_axis_frame_arb_mux;
  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [S*8-1:0] s_tdata;
  logic [S-1:0] s_tkeep, s_tvalid, s_tready, s_tlast, s_tuser;
  logic [7:0]   m_tdata;
  logic [0:0]   m_tkeep, m_tuser;
  logic         m_tvalid, m_tready, m_tlast, gv;
  logic [1:0]   gi;

  axis_frame_arb_mux dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .grant_valid(gv), .grant_index(gi)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    int         src;
    logic [7:0] data;
    logic       last;
    logic [3:0] e_rdy;
    logic       e_gv;
    logic [1:0] e_gi;
    logic       e_mv;
    logic [7:0] e_md;
    logic       e_ml;
  } vec_t;
  vec_t tbl[14];

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;
  } beat_t;
  beat_t srcq[S][$];
  int    waitc[S];
  int    exp_g[$];
  logic [7:0] exp_d[$];
  logic  exp_l[$];

  task automatic add_frame(input int i, input logic [7:0] base, input int n,
                           input int first_gap, input int mid_beat, input int mid_gap);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + 8'(k);
      b.last = (k == n - 1);
      b.gap  = (k == 0) ? first_gap : ((k == mid_beat) ? mid_gap : 0);
      srcq[i].push_back(b);
    end
  endtask

  task automatic add_exp(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      exp_d.push_back(base + 8'(k));
      exp_l.push_back(k == n - 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_g.delete(); exp_d.delete(); exp_l.delete();
  endtask

  task automatic run_traffic(input string name, input int max_cyc, input int stall_at,
                             input int stall_len, input bit chk_gap);
    int cyc, bad_rdy, glitch, unstable, stall_acc, gap_err;
    logic prev_gv, prev_hold, prev_ml, all_empty;
    logic [1:0] prev_gi;
    logic [7:0] prev_md;
    logic [3:0] allowed, acc;
    logic [7:0] got_d[$];
    logic got_l[$];
    int got_c[$];
    int grants[$];
    cyc = 0; bad_rdy = 0; glitch = 0; unstable = 0; stall_acc = 0; gap_err = 0;
    prev_gv = 1'b0; prev_hold = 1'b0; prev_ml = 1'b0; prev_gi = '0; prev_md = '0;
    for (int i = 0; i < S; i++) waitc[i] = (srcq[i].size() > 0) ? srcq[i][0].gap : 0;
    while (cyc < max_cyc) begin
      all_empty = 1'b1;
      for (int i = 0; i < S; i++) if (srcq[i].size() > 0) all_empty = 1'b0;
      if (all_empty && got_d.size() >= exp_d.size()) break;
      @(negedge clk);
      m_tready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tuser = '0;
      for (int i = 0; i < S; i++) begin
        if (srcq[i].size() > 0 && waitc[i] == 0) begin
          s_tvalid[i]      = 1'b1;
          s_tdata[i*8 +: 8] = srcq[i][0].data;
          s_tlast[i]       = srcq[i][0].last;
          s_tuser[i]       = ^srcq[i][0].data;
        end
      end
      #1;
      allowed = gv ? (4'b0001 << gi) : 4'b0000;
      if ((s_tready & ~allowed) != 4'b0000) bad_rdy++;
      if (gv && prev_gv && gi != prev_gi) glitch++;
      if (gv && !prev_gv) grants.push_back(int'(gi));
      if (prev_hold && (!m_tvalid || m_tdata !== prev_md || m_tlast !== prev_ml)) unstable++;
      prev_hold = m_tvalid && !m_tready;
      prev_md = m_tdata; prev_ml = m_tlast; prev_gv = gv; prev_gi = gi;
      if (m_tvalid && m_tready) begin
        got_d.push_back(m_tdata); got_l.push_back(m_tlast); got_c.push_back(cyc);
      end
      acc = s_tvalid & s_tready;
      if (!m_tready && acc != 4'b0000) stall_acc++;
      @(posedge clk);
      for (int i = 0; i < S; i++) begin
        if (acc[i]) begin
          void'(srcq[i].pop_front());
          waitc[i] = (srcq[i].size() > 0) ? srcq[i][0].gap : 0;
        end else if (srcq[i].size() > 0 && waitc[i] > 0) begin
          waitc[i]--;
        end
      end
      cyc++;
    end
    check({name, " finished in budget"}, int'(cyc < max_cyc), 1);
    check({name, " grant count"}, grants.size(), exp_g.size());
    for (int k = 0; k < grants.size() && k < exp_g.size(); k++)
      check($sformatf("%s grant[%0d]", name, k), grants[k], exp_g[k]);
    check({name, " beat count"}, got_d.size(), exp_d.size());
    for (int k = 0; k < got_d.size() && k < exp_d.size(); k++)
      check($sformatf("%s beat[%0d] data/last", name, k),
            int'({got_d[k], got_l[k]}), int'({exp_d[k], exp_l[k]}));
    check({name, " tready on non-granted input"}, bad_rdy, 0);
    check({name, " grant change mid-frame"}, glitch, 0);
    check({name, " output unstable under backpressure"}, unstable, 0);
    if (chk_gap) begin
      for (int k = 1; k < got_c.size(); k++)
        if (got_c[k] - got_c[k-1] != (got_l[k-1] ? 2 : 1)) gap_err++;
      check({name, " inter-beat spacing errors"}, gap_err, 0);
    end
    if (stall_len > 0) check({name, " beats accepted during stall <= 2"}, int'(stall_acc <= 2), 1);
    s_tvalid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ok;
    rst = 1'b1; s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
    m_tready = 1'b1;
    //        rst  vld      src data   last  e_rdy    gv    gi     mv    md     ml
    tbl[0]  = '{1'b0, 4'b0100, 2, 8'h11, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 4'b0100, 2, 8'h11, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 4'b0100, 2, 8'h22, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 8'h11, 1'b0};
    tbl[3]  = '{1'b0, 4'b0100, 2, 8'h33, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 8'h22, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 2, 8'h00, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1, 8'h33, 1'b1};
    tbl[5]  = '{1'b0, 4'b0000, 2, 8'h00, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 4'b1000, 3, 8'hA0, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 4'b1000, 3, 8'hA0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{1'b0, 4'b1000, 3, 8'hA1, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 8'hA0, 1'b0};
    tbl[9]  = '{1'b1, 4'b1000, 3, 8'hA2, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 8'hA1, 1'b0};
    tbl[10] = '{1'b0, 4'b0010, 1, 8'h55, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 4'b0010, 1, 8'h55, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{1'b0, 4'b0000, 1, 8'h00, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b1, 8'h55, 1'b1};
    tbl[13] = '{1'b0, 4'b0000, 1, 8'h00, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 8'h00, 1'b0};
    repeat (2) @(negedge clk);

    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      rst = tbl[v].rst; s_tvalid = tbl[v].vld; m_tready = 1'b1;
      s_tdata = '0; s_tlast = '0; s_tuser = '0;
      s_tdata[tbl[v].src*8 +: 8] = tbl[v].data;
      s_tlast[tbl[v].src] = tbl[v].last;
      s_tuser[tbl[v].src] = ^tbl[v].data;
      #1;
      ok = (s_tready === tbl[v].e_rdy) && (gv === tbl[v].e_gv) && (gi === tbl[v].e_gi) &&
           (m_tvalid === tbl[v].e_mv) &&
           (!tbl[v].e_mv || (m_tdata === tbl[v].e_md && m_tlast === tbl[v].e_ml &&
                             m_tuser[0] === ^tbl[v].e_md && m_tkeep === 1'b1));
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL vec%0d: got rdy=%b gv=%b gi=%0d mv=%b md=%h ml=%b mu=%b mk=%b, expected rdy=%b gv=%b gi=%0d mv=%b md=%h ml=%b",
                 v, s_tready, gv, gi, m_tvalid, m_tdata, m_tlast, m_tuser, m_tkeep,
                 tbl[v].e_rdy, tbl[v].e_gv, tbl[v].e_gi, tbl[v].e_mv, tbl[v].e_md, tbl[v].e_ml);
      end
    end

    // Round robin after reset: all inputs queued, input 0 holds a second frame.
    do_reset();
    add_frame(0, 8'h10, 2, 0, 0, 0); add_frame(0, 8'h14, 2, 0, 0, 0);
    add_frame(1, 8'h20, 2, 0, 0, 0); add_frame(2, 8'h30, 2, 0, 0, 0);
    add_frame(3, 8'h40, 2, 0, 0, 0);
    exp_g = '{0, 1, 2, 3, 0};
    add_exp(8'h10, 2); add_exp(8'h20, 2); add_exp(8'h30, 2); add_exp(8'h40, 2); add_exp(8'h14, 2);
    run_traffic("rotate", 100, 1000, 0, 1'b1);

    // Input 0 requests while input 1 is mid-frame.
    do_reset();
    add_frame(1, 8'h60, 4, 0, 0, 0); add_frame(0, 8'h70, 2, 2, 0, 0);
    exp_g = '{1, 0};
    add_exp(8'h60, 4); add_exp(8'h70, 2);
    run_traffic("late_req", 100, 1000, 0, 1'b1);

    // Output backpressure for 5 cycles mid-frame.
    do_reset();
    add_frame(2, 8'h80, 8, 0, 0, 0);
    exp_g = '{2};
    add_exp(8'h80, 8);
    run_traffic("stall", 100, 3, 5, 1'b0);

    // Granted input drops tvalid for 3 cycles while input 3 waits.
    do_reset();
    add_frame(1, 8'h90, 4, 0, 2, 3); add_frame(3, 8'hA5, 1, 1, 0, 0);
    exp_g = '{1, 3};
    add_exp(8'h90, 4); add_exp(8'hA5, 1);
    run_traffic("src_gap", 100, 1000, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
